// File: rtl/mpq_cmd_sched.sv
// Front-end scheduler for the max-priority-queue engine: load pass-through, round-robin
// command issue with a one-cycle holdoff, and a drain phase that waits for engine done.
module mpq_cmd_sched #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_cmd,
  input  logic [8*NREQ-1:0]    req_index,
  input  logic [8*NREQ-1:0]    req_value,
  output logic [NREQ-1:0]      req_grant,
  output logic                 mpq_data_valid,
  output logic [7:0]           mpq_data,
  output logic                 mpq_cmd_valid,
  output logic [2:0]           mpq_cmd,
  output logic [7:0]           mpq_index,
  output logic [7:0]           mpq_value,
  input  logic                 mpq_busy,
  input  logic                 mpq_done,
  output logic [1:0]           phase,
  output logic [CNTW-1:0]      issued_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              seen_q, seen_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic              dv_q, dv_d;
  logic [7:0]        data_q, data_d;
  logic              cv_q, cv_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        val_q, val_d;
  logic [NREQ-1:0]   grant_q, grant_d;

  logic              found;
  logic [PW-1:0]     win;
  logic              issue;
  logic [2:0]        win_cmd;
  logic              win_is_wo;

  // Rotating priority: the first requester at or above rr_q wins.
  always_comb begin : arb
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // cv_q blocks back-to-back issue before the engine has had a cycle to raise busy.
  assign issue     = found && !mpq_busy && !cv_q;
  assign win_cmd   = req_cmd[win*3 +: 3];
  assign win_is_wo = (win_cmd == 3'd4) || (win_cmd == 3'd6) || (win_cmd == 3'd7);

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    dv_d    = 1'b0;
    data_d  = data_q;
    cv_d    = 1'b0;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    val_d   = val_q;
    grant_d = '0;
    case (state_q)
      ST_LOAD: begin
        dv_d   = ld_valid;
        data_d = ld_data;
        if (ld_valid) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d  = 1'b0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (issue) begin
          cv_d         = 1'b1;
          cmd_d        = win_cmd;
          idx_d        = req_index[win*8 +: 8];
          val_d        = req_value[win*8 +: 8];
          grant_d[win] = 1'b1;
          rr_d         = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          cnt_d        = cnt_q + CNTW'(1);
          if (win_is_wo) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mpq_done) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
    ld_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      seen_q     <= 1'b0;
      rr_q       <= '0;
      cnt_q      <= '0;
      ld_ready_q <= 1'b1;
      dv_q       <= 1'b0;
      data_q     <= '0;
      cv_q       <= 1'b0;
      cmd_q      <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ld_ready_q <= ld_ready_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      cv_q       <= cv_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      grant_q    <= grant_d;
    end
  end

  assign ld_ready       = ld_ready_q;
  assign req_grant      = grant_q;
  assign mpq_data_valid = dv_q;
  assign mpq_data       = data_q;
  assign mpq_cmd_valid  = cv_q;
  assign mpq_cmd        = cmd_q;
  assign mpq_index      = idx_q;
  assign mpq_value      = val_q;
  assign phase          = state_q;
  assign issued_cnt     = cnt_q;

endmodule

// File: tb/tb_mpq_cmd_sched.sv
// Scoreboarded bench for mpq_cmd_sched with behavioural requesters and engine busy model.
module tb_mpq_cmd_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_cmd = '0;
  logic [31:0] req_index = '0;
  logic [31:0] req_value = '0;
  logic [3:0]  req_grant;
  logic        mpq_data_valid;
  logic [7:0]  mpq_data;
  logic        mpq_cmd_valid;
  logic [2:0]  mpq_cmd;
  logic [7:0]  mpq_index;
  logic [7:0]  mpq_value;
  logic        mpq_busy = 1'b0;
  logic        mpq_done;
  logic [1:0]  phase;
  logic [15:0] issued_cnt;

  mpq_cmd_sched #(.NREQ(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_index(req_index), .req_value(req_value),
    .req_grant(req_grant),
    .mpq_data_valid(mpq_data_valid), .mpq_data(mpq_data),
    .mpq_cmd_valid(mpq_cmd_valid), .mpq_cmd(mpq_cmd), .mpq_index(mpq_index), .mpq_value(mpq_value),
    .mpq_busy(mpq_busy), .mpq_done(mpq_done),
    .phase(phase), .issued_cnt(issued_cnt)
  );

  typedef struct packed {
    logic [2:0] c;
    logic [7:0] i;
    logic [7:0] v;
  } cmd_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          dv_cnt = 0;
  logic [31:0] sb[$];
  logic [7:0]  dq[$];
  logic [31:0] e;
  logic [7:0]  ed;
  cmd_t        rq_mem[4][8];
  int          rq_head[4];
  int          rq_tail[4];
  int          busy_cnt = 0;
  int          busy_len = 3;
  bit          eng_auto = 1'b1;
  logic [7:0]  ldv[5] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8};
  logic [3:0]  pat;
  bit          found;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_req(input int r, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
    cmd_t x;
    x.c = c; x.i = i; x.v = v;
    rq_mem[r][rq_tail[r] % 8] = x;
    rq_tail[r]++;
  endtask

  task automatic exp_issue(input logic [3:0] g, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
    sb.push_back({9'b0, c, i, v, g});
  endtask

  // Requesters: each grant consumes the head command; the next one is presented next cycle.
  always @(negedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (req_grant[r] && rq_head[r] < rq_tail[r]) rq_head[r]++;
      req_valid[r]         = (rq_head[r] < rq_tail[r]);
      req_cmd[3*r +: 3]    = rq_mem[r][rq_head[r] % 8].c;
      req_index[8*r +: 8]  = rq_mem[r][rq_head[r] % 8].i;
      req_value[8*r +: 8]  = rq_mem[r][rq_head[r] % 8].v;
    end
  end

  // Engine: busy for busy_len cycles after each accepted command.
  always @(negedge clk) begin
    if (!rst || !eng_auto) busy_cnt = 0;
    else begin
      if (busy_cnt > 0) busy_cnt--;
      if (mpq_cmd_valid) busy_cnt = busy_len;
    end
    mpq_busy = (busy_cnt > 0);
  end

  always @(negedge clk) begin
    if (mpq_cmd_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_issue: got cmd %0d idx 0x%0h grant %b, expected no issue",
                 mpq_cmd, mpq_index, req_grant);
      end else begin
        e = sb.pop_front();
        chk("issue", {9'b0, mpq_cmd, mpq_index, mpq_value, req_grant}, e);
      end
    end else begin
      chk("grant_idle", {28'b0, req_grant}, 32'h0);
    end
    if (mpq_data_valid) begin
      dv_cnt++;
      if (dq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_data: got 0x%0h, expected no beat", mpq_data);
      end else begin
        ed = dq.pop_front();
        chk("ld_stream", {24'b0, mpq_data}, {24'b0, ed});
      end
    end
  end

  task automatic do_load();
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1;
      ld_data  = ldv[k];
      dq.push_back(ldv[k]);
      @(posedge clk); #1;
      chk("ld_dv", {31'b0, mpq_data_valid}, 32'd1);
      chk("ld_latency", {24'b0, mpq_data}, {24'b0, ldv[k]});
      chk("ld_phase", {30'b0, phase}, 32'd0);
    end
    ld_valid = 1'b0;
    ld_data  = 8'hEE;
    @(posedge clk); #1;
    chk("gap_dv", {31'b0, mpq_data_valid}, 32'd0);
    chk("gap_phase", {30'b0, phase}, 32'd1);
    chk("gap_ld_ready", {31'b0, ld_ready}, 32'd0);
  endtask

  task automatic reset_and_load();
    mpq_done = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_load();
  endtask

  task automatic wait_sb(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; mpq_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_phase", {30'b0, phase}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_cmd_valid", {31'b0, mpq_cmd_valid}, 32'd0);
    chk("rst_data_valid", {31'b0, mpq_data_valid}, 32'd0);
    chk("rst_issued", {16'b0, issued_cnt}, 32'd0);
    chk("rst_grant", {28'b0, req_grant}, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_no_beat_phase", {30'b0, phase}, 32'd0);
    chk("idle_no_beat_ready", {31'b0, ld_ready}, 32'd1);

    // Load 9,3,7,1,8 then gap
    do_load();
    chk("dv_count", dv_cnt, 32'd5);

    // Single requester, one build command
    eng_auto = 1'b1; busy_len = 2;
    push_req(0, 3'd0, 8'h05, 8'h11);
    exp_issue(4'b0001, 3'd0, 8'h05, 8'h11);
    wait_sb(40);
    repeat (8) @(posedge clk); #1;
    chk("single_issued", {16'b0, issued_cnt}, 32'd1);
    chk("single_phase", {30'b0, phase}, 32'd1);

    // Round robin across requesters 0,1,3
    reset_and_load();
    mpq_done = 1'b1;
    @(posedge clk); #1;
    mpq_done = 1'b0;
    chk("done_ignored_cmd", {30'b0, phase}, 32'd1);
    busy_len = 3;
    push_req(0, 3'd1, 8'h10, 8'hA0); push_req(0, 3'd2, 8'h11, 8'hA1);
    push_req(1, 3'd3, 8'h20, 8'hB0); push_req(1, 3'd5, 8'h21, 8'hB1);
    push_req(3, 3'd1, 8'h30, 8'hC0); push_req(3, 3'd2, 8'h31, 8'hC1);
    exp_issue(4'b0001, 3'd1, 8'h10, 8'hA0);
    exp_issue(4'b0010, 3'd3, 8'h20, 8'hB0);
    exp_issue(4'b1000, 3'd1, 8'h30, 8'hC0);
    exp_issue(4'b0001, 3'd2, 8'h11, 8'hA1);
    exp_issue(4'b0010, 3'd5, 8'h21, 8'hB1);
    exp_issue(4'b1000, 3'd2, 8'h31, 8'hC1);
    wait_sb(200);
    chk("rr_issued", {16'b0, issued_cnt}, 32'd6);

    // Write-out from requester 2 while requester 1 still pending
    push_req(1, 3'd1, 8'h40, 8'hD0); push_req(1, 3'd2, 8'h41, 8'hD1);
    push_req(2, 3'd4, 8'h50, 8'hE0);
    exp_issue(4'b0010, 3'd1, 8'h40, 8'hD0);
    exp_issue(4'b0100, 3'd4, 8'h50, 8'hE0);
    wait_sb(100);
    repeat (6) @(posedge clk); #1;
    chk("drain_phase", {30'b0, phase}, 32'd2);
    chk("drain_req1_pending", {31'b0, req_valid[1]}, 32'd1);
    chk("drain_issued", {16'b0, issued_cnt}, 32'd8);
    mpq_done = 1'b1;
    @(posedge clk); #1;
    mpq_done = 1'b0;
    chk("done_phase", {30'b0, phase}, 32'd0);
    chk("done_ld_ready", {31'b0, ld_ready}, 32'd1);
    rq_tail[1] = rq_head[1];

    // Engine idle for several cycles: holdoff gives 1,0,1,0
    reset_and_load();
    eng_auto = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_req(0, 3'd0, 8'(8'h60 + k), 8'(8'h70 + k));
      exp_issue(4'b0001, 3'd0, 8'(8'h60 + k), 8'(8'h70 + k));
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mpq_cmd_valid) found = 1'b1;
    end
    chk("holdoff_first_issue", {31'b0, found}, 32'd1);
    pat = {3'b000, mpq_cmd_valid};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pat = {pat[2:0], mpq_cmd_valid};
    end
    chk("holdoff_pattern", {28'b0, pat}, 32'hA);
    wait_sb(40);
    chk("holdoff_issued", {16'b0, issued_cnt}, 32'd4);

    // Reset asserted during drain
    reset_and_load();
    eng_auto = 1'b1; busy_len = 30;
    push_req(0, 3'd6, 8'h77, 8'h88);
    exp_issue(4'b0001, 3'd6, 8'h77, 8'h88);
    wait_sb(40);
    chk("pre_rst_phase", {30'b0, phase}, 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_phase", {30'b0, phase}, 32'd0);
    chk("arst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("arst_cmd_valid", {31'b0, mpq_cmd_valid}, 32'd0);
    chk("arst_fields", {8'b0, mpq_cmd, mpq_index, mpq_value}, 32'd0);
    chk("arst_data", {23'b0, mpq_data_valid, mpq_data}, 32'd0);
    chk("arst_grant", {28'b0, req_grant}, 32'd0);
    chk("arst_issued", {16'b0, issued_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_phase", {30'b0, phase}, 32'd0);
    chk("post_rst_issued", {16'b0, issued_cnt}, 32'd0);

    chk("sb_empty_end", sb.size(), 32'd0);
    chk("dq_empty_end", dq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
